lm32_shifter_pipe: RTL and testbench

LM32_SHIFTER_PIPE -- requirements
Module: lm32_shifter_pipe

---
 rtl/lm32_shifter_pkg.sv | 27 ++
 rtl/lm32_shift_stage.sv | 75 +++++++
 rtl/lm32_shifter_pipe.sv | 105 ++++++++++
 tb/tb_lm32_shifter_pipe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lm32_shifter_pkg.sv
// Shared opcode encodings and helpers for the pipelined LM32 shifter.
// Rotate support is controlled by CFG_SHIFTER_ROTATE_EN (see lm32_shift_stage).
package lm32_shifter_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_SLL = 3'd0;
   localparam logic [OP_W-1:0] OP_SRL = 3'd1;
   localparam logic [OP_W-1:0] OP_SRA = 3'd2;
   localparam logic [OP_W-1:0] OP_ROL = 3'd3;
   localparam logic [OP_W-1:0] OP_ROR = 3'd4;

   // Amount bits handled per stage; the last stage takes whatever remains.
   function automatic int unsigned stage_bits(int unsigned amt_bits, int unsigned stages);
      return (amt_bits + stages - 1) / stages;
   endfunction

   // Left operations run through the right-shift datapath on bit-reversed data.
   function automatic logic is_left(logic [OP_W-1:0] op);
      return (op == OP_SLL) || (op == OP_ROL);
   endfunction

   function automatic logic is_rotate(logic [OP_W-1:0] op);
      return (op == OP_ROL) || (op == OP_ROR);
   endfunction

endpackage

// File: rtl/lm32_shift_stage.sv
// One pipeline slice: applies amount bits [LO, HI) as right shifts/rotates and
// registers data, opcode, amount and fill. Wrap logic exists only with CFG_SHIFTER_ROTATE_EN.
module lm32_shift_stage
   import lm32_shifter_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned LO    = 0,
   parameter int unsigned HI    = 1,
   parameter bit          LAST  = 1'b0,
   localparam int unsigned L    = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_x,
   input  logic             prev_valid,
   input  logic [OP_W-1:0]  prev_op,
   input  logic [L-1:0]     prev_amt,
   input  logic             prev_fill,
   input  logic [WIDTH-1:0] prev_data,
   output logic             valid,
   output logic [OP_W-1:0]  op,
   output logic [L-1:0]     amt,
   output logic             fill,
   output logic [WIDTH-1:0] data
);

   localparam logic [WIDTH-1:0] ONES = '1;

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] wrap;
   logic [WIDTH-1:0] next_data;
   int unsigned      sh;

   // Conditional 2^j right steps for this slice's amount bits, then final un-reversal.
   always_comb begin
      shifted   = prev_data;
      wrap      = '0;
      next_data = '0;
      sh        = 0;
      for (int unsigned j = 0; j < L; j++) begin
         if (j >= LO && j < HI && prev_amt[j]) begin
            sh = 32'(1) << j;
`ifdef CFG_SHIFTER_ROTATE_EN
            wrap = is_rotate(prev_op) ? (shifted << (WIDTH - sh))
                                      : (prev_fill ? ~(ONES >> sh) : '0);
`else
            wrap = prev_fill ? ~(ONES >> sh) : '0;
`endif
            shifted = (shifted >> sh) | wrap;
         end
      end
      if (LAST && is_left(prev_op)) begin
         for (int unsigned i = 0; i < WIDTH; i++) next_data[i] = shifted[WIDTH-1-i];
      end else begin
         next_data = shifted;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid <= 1'b0;
         op    <= '0;
         amt   <= '0;
         fill  <= 1'b0;
         data  <= '0;
      end else if (!stall_x) begin
         valid <= prev_valid;
         op    <= prev_op;
         amt   <= prev_amt;
         fill  <= prev_fill;
         data  <= next_data;
      end
   end

endmodule

// File: rtl/lm32_shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with STAGES register slices.
// Rotates are true rotates only when CFG_SHIFTER_ROTATE_EN is defined.
module lm32_shifter_pipe
   import lm32_shifter_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_x,
   input  logic             valid_x,
   input  logic [OP_W-1:0]  op_x,
   input  logic [WIDTH-1:0] operand_0_x,
   input  logic [WIDTH-1:0] operand_1_x,
   output logic [WIDTH-1:0] result_m,
   output logic             valid_m
);

   localparam int unsigned L  = $clog2(WIDTH);
   localparam int unsigned SB = stage_bits(L, STAGES);

   logic             in_valid;
   logic [OP_W-1:0]  in_op;
   logic [L-1:0]     in_amt;
   logic             in_fill;
   logic [WIDTH-1:0] in_data;
   logic             op_ok;

   logic             valid_s [STAGES];
   logic [OP_W-1:0]  op_s    [STAGES];
   logic [L-1:0]     amt_s   [STAGES];
   logic             fill_s  [STAGES];
   logic [WIDTH-1:0] data_s  [STAGES];

   // Bubbles and reserved opcodes enter as zero data so they drain as result 0.
   always_comb begin
      op_ok    = (op_x <= OP_ROR);
      in_valid = valid_x;
      in_op    = valid_x ? op_x : '0;
      in_amt   = (valid_x && op_ok) ? operand_1_x[L-1:0] : '0;
      in_fill  = valid_x && (op_x == OP_SRA) && operand_0_x[WIDTH-1];
      in_data  = '0;
      if (valid_x && op_ok) begin
         if (is_left(op_x)) begin
            for (int unsigned i = 0; i < WIDTH; i++) in_data[i] = operand_0_x[WIDTH-1-i];
         end else begin
            in_data = operand_0_x;
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned LO = k * SB;
      localparam int unsigned HI = (k == STAGES - 1) ? L
                                 : (((k + 1) * SB < L) ? (k + 1) * SB : L);
      logic             src_valid;
      logic [OP_W-1:0]  src_op;
      logic [L-1:0]     src_amt;
      logic             src_fill;
      logic [WIDTH-1:0] src_data;

      if (k == 0) begin : g_first
         assign src_valid = in_valid;
         assign src_op    = in_op;
         assign src_amt   = in_amt;
         assign src_fill  = in_fill;
         assign src_data  = in_data;
      end else begin : g_next
         assign src_valid = valid_s[k-1];
         assign src_op    = op_s[k-1];
         assign src_amt   = amt_s[k-1];
         assign src_fill  = fill_s[k-1];
         assign src_data  = data_s[k-1];
      end

      lm32_shift_stage #(
         .WIDTH (WIDTH),
         .LO    (LO),
         .HI    (HI),
         .LAST  (k == STAGES - 1)
      ) u_stage (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .stall_x    (stall_x),
         .prev_valid (src_valid),
         .prev_op    (src_op),
         .prev_amt   (src_amt),
         .prev_fill  (src_fill),
         .prev_data  (src_data),
         .valid      (valid_s[k]),
         .op         (op_s[k]),
         .amt        (amt_s[k]),
         .fill       (fill_s[k]),
         .data       (data_s[k])
      );
   end

   assign result_m = data_s[STAGES-1];
   assign valid_m  = valid_s[STAGES-1];

   logic unused_ok;
   assign unused_ok = ^{operand_1_x[WIDTH-1:L], op_s[STAGES-1], amt_s[STAGES-1], fill_s[STAGES-1]};

endmodule

// File: tb/tb_lm32_shifter_pipe.sv
// Scoreboard bench for lm32_shifter_pipe: 32-bit/2-stage and 64-bit/6-stage instances.
// Expected rotate results follow CFG_SHIFTER_ROTATE_EN.
module tb_lm32_shifter_pipe;

`ifdef CFG_SHIFTER_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   typedef struct {
      logic [63:0] data;
      int unsigned due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;

   logic        valid_a = 1'b0;
   logic [2:0]  op_a = '0;
   logic [31:0] opnd0_a = '0, opnd1_a = '0, res_a;
   logic        vm_a;

   logic        valid_b = 1'b0;
   logic [2:0]  op_b = '0;
   logic [63:0] opnd0_b = '0, opnd1_b = '0, res_b;
   logic        vm_b;

   exp_t        q_a[$], q_b[$];
   exp_t        e_a, e_b;
   int unsigned adv_cnt = 0;
   bit          adv_last = 1'b0, hold_last = 1'b0;
   logic [31:0] prev_res_a = '0;
   logic [63:0] prev_res_b = '0;
   logic        prev_vm_a = 1'b0, prev_vm_b = 1'b0;
   int          checks = 0;
   int          errors = 0;

   lm32_shifter_pipe #(.WIDTH(32), .STAGES(2)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .stall_x(stall), .valid_x(valid_a), .op_x(op_a),
      .operand_0_x(opnd0_a), .operand_1_x(opnd1_a), .result_m(res_a), .valid_m(vm_a)
   );

   lm32_shifter_pipe #(.WIDTH(64), .STAGES(6)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .stall_x(stall), .valid_x(valid_b), .op_x(op_b),
      .operand_0_x(opnd0_b), .operand_1_x(opnd1_b), .result_m(res_b), .valid_m(vm_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Unstalled-edge counter: latency is measured in advancing cycles; reset flushes expectations.
   always @(posedge clk) begin
      adv_last  = !stall && !rst;
      hold_last = stall && !rst;
      if (adv_last) adv_cnt++;
      if (rst) begin
         q_a.delete();
         q_b.delete();
      end
   end

   always @(negedge clk) begin
      if (adv_last && vm_a) begin
         if (q_a.size() == 0) chk("a_unexpected_valid", 64'd1, 64'd0);
         else begin
            e_a = q_a.pop_front();
            chk("a_result", 64'(res_a), e_a.data);
            chk("a_latency", 64'(adv_cnt), 64'(e_a.due));
         end
      end
      if (hold_last) begin
         chk("a_stall_result", 64'(res_a), 64'(prev_res_a));
         chk("a_stall_valid", 64'(vm_a), 64'(prev_vm_a));
      end
      prev_res_a = res_a;
      prev_vm_a  = vm_a;
   end

   always @(negedge clk) begin
      if (adv_last && vm_b) begin
         if (q_b.size() == 0) chk("b_unexpected_valid", 64'd1, 64'd0);
         else begin
            e_b = q_b.pop_front();
            chk("b_result", res_b, e_b.data);
            chk("b_latency", 64'(adv_cnt), 64'(e_b.due));
         end
      end
      if (hold_last) chk("b_stall_result", res_b, prev_res_b);
      prev_res_b = res_b;
      prev_vm_b  = vm_b;
   end

   task automatic issue_a(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
      valid_a = 1'b1; op_a = op; opnd0_a = a; opnd1_a = b;
      q_a.push_back('{data: 64'(exp), due: adv_cnt + 2});
      @(posedge clk); #1;
      valid_a = 1'b0;
   endtask

   task automatic issue_b(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp);
      valid_b = 1'b1; op_b = op; opnd0_b = a; opnd1_b = b;
      q_b.push_back('{data: exp, due: adv_cnt + 6});
      @(posedge clk); #1;
      valid_b = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
      @(posedge clk); #1;
      chk("drain_a", 64'(q_a.size()), 64'd0);
      chk("drain_b", 64'(q_b.size()), 64'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_valid_a", 64'(vm_a), 64'd0);
      chk("reset_result_a", 64'(res_a), 64'd0);
      chk("reset_valid_b", 64'(vm_b), 64'd0);
      chk("reset_result_b", res_b, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      issue_a(3'd2, 32'h8000_0000, 32'd4, 32'hF800_0000);
      issue_a(3'd3, 32'h8000_0001, 32'd1, ROT ? 32'h0000_0003 : 32'h0000_0002);
      issue_a(3'd0, 32'h1, 32'd0,  32'h1);
      issue_a(3'd0, 32'h1, 32'd31, 32'h8000_0000);
      issue_a(3'd0, 32'h1, 32'd32, 32'h1);
      @(posedge clk); #1;
      issue_a(3'd1, 32'h8000_0000, 32'd31, 32'h1);
      issue_a(3'd2, 32'hF000_0000, 32'd28, 32'hFFFF_FFFF);
      issue_a(3'd2, 32'h7FFF_FFFF, 32'd31, 32'h0);
      issue_a(3'd0, 32'h1234_5678, 32'd4,  32'h2345_6780);
      issue_a(3'd4, 32'h1, 32'd4, ROT ? 32'h1000_0000 : 32'h0);
      issue_a(3'd3, 32'h1234_5678, 32'd8, ROT ? 32'h3456_7812 : 32'h3456_7800);
      issue_a(3'd4, 32'h1234_5678, 32'd0, 32'h1234_5678);
      issue_a(3'd5, 32'hFFFF_FFFF, 32'd3, 32'h0);
      issue_a(3'd7, 32'hFFFF_FFFF, 32'd0, 32'h0);
      drain();

      // Stall mid-flight; inputs presented during the stall must be ignored.
      issue_a(3'd1, 32'hFFFF_0000, 32'd8, 32'h00FF_FF00);
      stall = 1'b1;
      valid_a = 1'b1; op_a = 3'd0; opnd0_a = 32'hDEAD_BEEF; opnd1_a = 32'd1;
      repeat (3) @(posedge clk);
      #1;
      stall = 1'b0;
      valid_a = 1'b0;
      drain();

      // Reset with two ops in flight (stall asserted too), then accept immediately.
      issue_a(3'd0, 32'h1, 32'd1, 32'h2);
      issue_a(3'd0, 32'h1, 32'd2, 32'h4);
      rst = 1'b1;
      stall = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      stall = 1'b0;
      valid_a = 1'b1; op_a = 3'd1; opnd0_a = 32'h100; opnd1_a = 32'd8;
      q_a.push_back('{data: 64'h1, due: adv_cnt + 2});
      @(negedge clk);
      chk("post_reset_valid_0", 64'(vm_a), 64'd0);
      chk("post_reset_result_0", 64'(res_a), 64'd0);
      @(posedge clk); #1;
      valid_a = 1'b0;
      @(negedge clk);
      chk("post_reset_valid_1", 64'(vm_a), 64'd0);
      chk("post_reset_result_1", 64'(res_a), 64'd0);
      drain();

      issue_b(3'd4, 64'h1, 64'd1, ROT ? 64'h8000_0000_0000_0000 : 64'h0);
      issue_b(3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h0);
      issue_b(3'd2, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF);
      issue_b(3'd0, 64'h1, 64'd63, 64'h8000_0000_0000_0000);
      issue_b(3'd3, 64'h8000_0000_0000_0001, 64'd4, ROT ? 64'h18 : 64'h10);
      issue_b(3'd1, 64'hFFFF_0000_0000_0000, 64'd40, 64'h0000_0000_00FF_FF00);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
